ycbcr422_to_rgb888: RTL and testbench

// - Downstream stage of the BT.656 receiver, in the AXI clock domain.
// - Consumes the 8-bit YCbCr 4:2:2 AXI4-Stream (Cb,Y0,Cr,Y1 byte order, tuser=SOF, tlast=EOL).
// - Emits one 24-bit RGB888 pixel per luma sample, toward the VDMA/display path.
// - BT.601 colour matrix, fixed-point, clamped; 3-stage pipeline with full backpressure.

---
 rtl/video_pkg.sv | 35 +++
 rtl/ycbcr422_to_rgb888_if.sv | 13 +
 rtl/ycbcr2rgb_core.sv | 78 +++++++
 rtl/ycbcr422_to_rgb888.sv | 137 +++++++++++++
 tb/tb_ycbcr422_to_rgb888.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
// Shared types and constants for the YCbCr 4:2:2 -> RGB888 converter.
// Holds the pair phase enum, BT.601 coefficients for both ranges and datapath widths.
`timescale 1ns/1ps
package video_pkg;

  typedef enum logic [1:0] {
    PH_CB = 2'd0,
    PH_Y0 = 2'd1,
    PH_CR = 2'd2,
    PH_Y1 = 2'd3
  } phase_e;

  localparam int CW = 9;   // centred component
  localparam int PW = 19;  // single product
  localparam int SW = 21;  // matrix sum

  localparam int LR_KY  = 298;
  localparam int LR_RCR = 409;
  localparam int LR_GCB = 100;
  localparam int LR_GCR = 208;
  localparam int LR_BCB = 516;

  localparam int FR_KY  = 256;
  localparam int FR_RCR = 359;
  localparam int FR_GCB = 88;
  localparam int FR_GCR = 183;
  localparam int FR_BCB = 454;

  function automatic logic [7:0] clamp_u8(input logic signed [SW-1:0] v);
    if (v < 0)        return 8'd0;
    else if (v > 255) return 8'd255;
    else              return v[7:0];
  endfunction

endpackage

// File: rtl/ycbcr422_to_rgb888_if.sv
// RGB888 pixel stream bundle between the colour core and the output port.
// Valid/ready: a pixel moves on a clock edge where tvalid && tready; while tvalid is high and tready low, tdata/tuser/tlast hold.
`timescale 1ns/1ps
interface ycbcr422_to_rgb888_if;
  logic [23:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/ycbcr2rgb_core.sv
// Three-stage BT.601 colour matrix: centre, multiply, round/shift/clamp.
// The whole pipe, including sideband, freezes while stall_i is high.
`timescale 1ns/1ps
module ycbcr2rgb_core
  import video_pkg::*;
#(
  parameter bit FULL_RANGE = 1'b0,
  parameter int COEF_FRAC  = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       stall_i,
  input  logic       valid_i,
  input  logic [7:0] y_i,
  input  logic [7:0] cb_i,
  input  logic [7:0] cr_i,
  input  logic       user_i,
  input  logic       last_i,
  ycbcr422_to_rgb888_if.master m_o
);

  localparam int KY    = FULL_RANGE ? FR_KY  : LR_KY;
  localparam int RCR   = FULL_RANGE ? FR_RCR : LR_RCR;
  localparam int GCB   = FULL_RANGE ? FR_GCB : LR_GCB;
  localparam int GCR   = FULL_RANGE ? FR_GCR : LR_GCR;
  localparam int BCB   = FULL_RANGE ? FR_BCB : LR_BCB;
  localparam int Y_OFF = FULL_RANGE ? 0 : 16;

  localparam logic signed [PW-1:0] K_Y   = PW'(KY);
  localparam logic signed [PW-1:0] K_RCR = PW'(RCR);
  localparam logic signed [PW-1:0] K_GCB = PW'(GCB);
  localparam logic signed [PW-1:0] K_GCR = PW'(GCR);
  localparam logic signed [PW-1:0] K_BCB = PW'(BCB);
  localparam logic signed [SW-1:0] RND   = SW'(1 << (COEF_FRAC - 1));

  logic signed [CW-1:0] y_c, cb_c, cr_c;
  logic                 s1_v_q, s1_user_q, s1_last_q;
  logic signed [CW-1:0] s1_y_q, s1_cb_q, s1_cr_q;
  logic signed [PW-1:0] py_d, rcr_d, gcb_d, gcr_d, bcb_d;
  logic                 s2_v_q, s2_user_q, s2_last_q;
  logic signed [PW-1:0] s2_py_q, s2_rcr_q, s2_gcb_q, s2_gcr_q, s2_bcb_q;
  logic signed [SW-1:0] r_sum, g_sum, b_sum;
  logic [23:0]          rgb_d;

  assign y_c  = $signed({1'b0, y_i})  - $signed(CW'(Y_OFF));
  assign cb_c = $signed({1'b0, cb_i}) - $signed(CW'(128));
  assign cr_c = $signed({1'b0, cr_i}) - $signed(CW'(128));

  assign py_d  = K_Y   * PW'(s1_y_q);
  assign rcr_d = K_RCR * PW'(s1_cr_q);
  assign gcb_d = K_GCB * PW'(s1_cb_q);
  assign gcr_d = K_GCR * PW'(s1_cr_q);
  assign bcb_d = K_BCB * PW'(s1_cb_q);

  assign r_sum = SW'(s2_py_q) + SW'(s2_rcr_q) + RND;
  assign g_sum = SW'(s2_py_q) - SW'(s2_gcb_q) - SW'(s2_gcr_q) + RND;
  assign b_sum = SW'(s2_py_q) + SW'(s2_bcb_q) + RND;
  assign rgb_d = {clamp_u8(r_sum >>> COEF_FRAC),
                  clamp_u8(g_sum >>> COEF_FRAC),
                  clamp_u8(b_sum >>> COEF_FRAC)};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_v_q <= 1'b0; s1_user_q <= 1'b0; s1_last_q <= 1'b0;
      s1_y_q <= '0;   s1_cb_q   <= '0;   s1_cr_q   <= '0;
      s2_v_q <= 1'b0; s2_user_q <= 1'b0; s2_last_q <= 1'b0;
      s2_py_q <= '0; s2_rcr_q <= '0; s2_gcb_q <= '0; s2_gcr_q <= '0; s2_bcb_q <= '0;
      m_o.tvalid <= 1'b0; m_o.tdata <= '0; m_o.tuser <= 1'b0; m_o.tlast <= 1'b0;
    end else if (!stall_i) begin
      s1_v_q <= valid_i; s1_user_q <= user_i; s1_last_q <= last_i;
      s1_y_q <= y_c;     s1_cb_q   <= cb_c;   s1_cr_q   <= cr_c;
      s2_v_q <= s1_v_q;  s2_user_q <= s1_user_q; s2_last_q <= s1_last_q;
      s2_py_q <= py_d; s2_rcr_q <= rcr_d; s2_gcb_q <= gcb_d; s2_gcr_q <= gcr_d; s2_bcb_q <= bcb_d;
      m_o.tvalid <= s2_v_q; m_o.tdata <= rgb_d; m_o.tuser <= s2_user_q; m_o.tlast <= s2_last_q;
    end
  end

endmodule

// File: rtl/ycbcr422_to_rgb888.sv
// YCbCr 4:2:2 AXI4-Stream to RGB888: pair-phase tracking, chroma capture,
// alignment checking and stream handshake around the colour core.
`timescale 1ns/1ps
module ycbcr422_to_rgb888
  import video_pkg::*;
#(
  parameter bit FULL_RANGE = 1'b0,
  parameter int COEF_FRAC  = 8
) (
  input  logic        axi_clk_i,
  input  logic        axi_rstn_i,
  input  logic        en_i,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  output logic [23:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        err_o,
  input  logic        err_clr_i
);

  ycbcr422_to_rgb888_if pix_if ();

  phase_e     phase_q, phase_d, eff_ph;
  logic       run_q, adv, fire, err_set, err_q;
  logic [7:0] cb_q, y0_q, cr_q;
  logic       sof_q;
  logic       iss_v_q, iss_v_d, iss_user_q, iss_user_d, iss_last_q, iss_last_d;
  logic [7:0] iss_y_q, iss_y_d, iss_cb_q, iss_cr_q, iss_cr_d;

  // run_q keeps tready low while reset is asserted, even with en_i high.
  assign adv           = !pix_if.tvalid || pix_if.tready;
  assign s_axis_tready = adv && en_i && run_q;
  assign fire          = s_axis_tvalid && s_axis_tready;
  assign eff_ph        = s_axis_tuser ? PH_CB : phase_q;

  always_comb begin
    phase_d    = phase_q;
    err_set    = 1'b0;
    iss_v_d    = 1'b0;
    iss_y_d    = s_axis_tdata;
    iss_cr_d   = cr_q;
    iss_user_d = 1'b0;
    iss_last_d = 1'b0;
    if (!en_i) begin
      phase_d = PH_CB;
    end else if (fire) begin
      if (s_axis_tlast && eff_ph != PH_Y1) begin
        err_set = 1'b1;
        phase_d = PH_CB;
      end else begin
        case (eff_ph)
          PH_CB: phase_d = PH_Y0;
          PH_Y0: phase_d = PH_CR;
          PH_CR: begin
            phase_d    = PH_Y1;
            iss_v_d    = 1'b1;
            iss_y_d    = y0_q;
            iss_cr_d   = s_axis_tdata;
            iss_user_d = sof_q;
          end
          default: begin
            phase_d    = PH_CB;
            iss_v_d    = 1'b1;
            iss_last_d = s_axis_tlast;
          end
        endcase
      end
    end
  end

  always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
    if (!axi_rstn_i) begin
      run_q   <= 1'b0;
      phase_q <= PH_CB;
      err_q   <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      phase_q <= phase_d;
      if (err_clr_i)    err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
    end
  end

  always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
    if (!axi_rstn_i) begin
      cb_q <= '0; y0_q <= '0; cr_q <= '0; sof_q <= 1'b0;
    end else if (fire) begin
      case (eff_ph)
        PH_CB: begin cb_q <= s_axis_tdata; sof_q <= s_axis_tuser; end
        PH_Y0: y0_q <= s_axis_tdata;
        PH_CR: cr_q <= s_axis_tdata;
        default: ;
      endcase
    end
  end

  // Issue register: the first pipe slot, frozen with the rest of the pipe.
  always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
    if (!axi_rstn_i) begin
      iss_v_q <= 1'b0; iss_user_q <= 1'b0; iss_last_q <= 1'b0;
      iss_y_q <= '0;   iss_cb_q   <= '0;   iss_cr_q   <= '0;
    end else if (adv) begin
      iss_v_q <= iss_v_d; iss_user_q <= iss_user_d; iss_last_q <= iss_last_d;
      iss_y_q <= iss_y_d; iss_cb_q   <= cb_q;       iss_cr_q   <= iss_cr_d;
    end
  end

  ycbcr2rgb_core #(
    .FULL_RANGE (FULL_RANGE),
    .COEF_FRAC  (COEF_FRAC)
  ) u_core (
    .clk_i   (axi_clk_i),
    .rst_ni  (axi_rstn_i),
    .stall_i (!adv),
    .valid_i (iss_v_q),
    .y_i     (iss_y_q),
    .cb_i    (iss_cb_q),
    .cr_i    (iss_cr_q),
    .user_i  (iss_user_q),
    .last_i  (iss_last_q),
    .m_o     (pix_if)
  );

  assign pix_if.tready = m_axis_tready;
  assign m_axis_tdata  = pix_if.tdata;
  assign m_axis_tvalid = pix_if.tvalid;
  assign m_axis_tuser  = pix_if.tuser;
  assign m_axis_tlast  = pix_if.tlast;
  assign err_o         = err_q;

endmodule

// File: tb/tb_ycbcr422_to_rgb888.sv
// Directed bench for ycbcr422_to_rgb888: known colours, latency, alignment errors,
// enable flush, a backpressured 1280-beat line and an asynchronous mid-line reset.
`timescale 1ns/1ps
module tb_ycbcr422_to_rgb888;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, err_clr, err;
  logic [7:0] s_tdata;
  logic       s_tvalid, s_tready, s_tuser, s_tlast;

  ycbcr422_to_rgb888_if snk ();

  ycbcr422_to_rgb888 #(.FULL_RANGE(1'b0), .COEF_FRAC(8)) dut (
    .axi_clk_i     (clk),
    .axi_rstn_i    (rst_n),
    .en_i          (en),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tuser  (s_tuser),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (snk.tdata),
    .m_axis_tvalid (snk.tvalid),
    .m_axis_tready (snk.tready),
    .m_axis_tuser  (snk.tuser),
    .m_axis_tlast  (snk.tlast),
    .err_o         (err),
    .err_clr_i     (err_clr)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic        mon_en = 1'b0;
  logic        bp_en  = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_word, cur_word, exp_word;
  int          lat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pw(input logic [23:0] d, input logic u, input logic l);
    return {6'b0, u, l, d};
  endfunction

  function automatic logic [7:0] sat8(input int x);
    if (x < 0)   return 8'd0;
    if (x > 255) return 8'd255;
    return 8'(x);
  endfunction

  // Golden BT.601 limited-range conversion in plain integer arithmetic.
  function automatic logic [23:0] ref_rgb(input int y, input int cb, input int cr);
    int yy, u, v, r, g, b;
    yy = 298 * (y - 16);
    u  = cb - 128;
    v  = cr - 128;
    r  = yy + 409 * v;
    g  = yy - 100 * u - 208 * v;
    b  = yy + 516 * u;
    return {sat8((r + 128) >>> 8), sat8((g + 128) >>> 8), sat8((b + 128) >>> 8)};
  endfunction

  function automatic logic [7:0] line_val(input int p, input int k);
    case (k)
      0:       return 8'((p * 37 + 11) & 255);
      1:       return 8'((p * 53 + 5) & 255);
      2:       return 8'((p * 29 + 200) & 255);
      default: return 8'((p * 71 + 100) & 255);
    endcase
  endfunction

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      cur_word = {5'b0, snk.tvalid, snk.tuser, snk.tlast, snk.tdata};
      if (prev_stall) check("stall_hold", cur_word, prev_word);
      prev_stall = snk.tvalid && !snk.tready;
      prev_word  = cur_word;
      if (snk.tvalid && snk.tready) begin
        if (exp_q.size() == 0) begin
          check("sb_extra", {6'b100000, cur_word[25:0]}, 32'd0);
        end else begin
          exp_word = exp_q.pop_front();
          check("sb_pix", {6'b0, cur_word[25:0]}, exp_word);
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (bp_en) begin
      #1;
      snk.tready = ($urandom_range(0, 99) >= 30);
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic u, input logic l);
    int waited;
    waited   = 0;
    s_tdata  = d;
    s_tuser  = u;
    s_tlast  = l;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!s_tready) check("beat_accept", 32'(s_tready), 32'd1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] cb, input logic [7:0] y0, input logic [7:0] cr,
                           input logic [7:0] y1, input logic sof, input logic eol);
    send_beat(cb, sof, 1'b0);
    send_beat(y0, 1'b0, 1'b0);
    send_beat(cr, 1'b0, 1'b0);
    send_beat(y1, 1'b0, eol);
  endtask

  task automatic drain(input string tag);
    int w;
    w = 0;
    repeat (6) @(negedge clk);
    while ((exp_q.size() != 0 || snk.tvalid) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    check({"drain_", tag}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_tvalid();
    lat = 0;
    while (!snk.tvalid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; err_clr = 1'b0;
    s_tdata = 8'd0; s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    snk.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 32'(snk.tvalid), 32'd0);
    check("rst_tdata",  32'(snk.tdata),  32'd0);
    check("rst_tuser",  32'(snk.tuser),  32'd0);
    check("rst_tlast",  32'(snk.tlast),  32'd0);
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_err",    32'(err),        32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Black then white with issue-to-output latency.
    exp_q.push_back(pw(24'h000000, 1'b1, 1'b0));
    exp_q.push_back(pw(24'hFFFFFF, 1'b0, 1'b1));
    send_beat(8'd128, 1'b1, 1'b0);
    send_beat(8'd16,  1'b0, 1'b0);
    send_beat(8'd128, 1'b0, 1'b0);
    wait_tvalid();
    check("lat_px0", 32'(lat), 32'd3);
    send_beat(8'd235, 1'b0, 1'b1);
    wait_tvalid();
    check("lat_px1", 32'(lat), 32'd3);
    drain("limited");

    // Saturated red.
    exp_q.push_back(pw(24'hFF0000, 1'b1, 1'b0));
    exp_q.push_back(pw(24'hFF0000, 1'b0, 1'b1));
    send_pair(8'd90, 8'd81, 8'd240, 8'd81, 1'b1, 1'b1);
    drain("red");

    // Extremes: clamping high and low without wrap.
    exp_q.push_back(pw(24'hFF7DFF, 1'b1, 1'b0));
    exp_q.push_back(pw(24'hFF7DFF, 1'b0, 1'b1));
    send_pair(8'd255, 8'd255, 8'd255, 8'd255, 1'b1, 1'b1);
    exp_q.push_back(pw(24'h008700, 1'b1, 1'b0));
    exp_q.push_back(pw(24'h008700, 1'b0, 1'b1));
    send_pair(8'd0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1);
    drain("extremes");

    // tlast on Y0: error, pair dropped, next beat is Cb.
    send_beat(8'd128, 1'b1, 1'b0);
    send_beat(8'd16,  1'b0, 1'b1);
    check("misalign_err", 32'(err), 32'd1);
    exp_q.push_back(pw(24'h000000, 1'b0, 1'b0));
    exp_q.push_back(pw(24'hFFFFFF, 1'b0, 1'b1));
    send_pair(8'd128, 8'd16, 8'd128, 8'd235, 1'b0, 1'b1);
    drain("misalign");
    check("err_sticky", 32'(err), 32'd1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("err_clear", 32'(err), 32'd0);
    err_clr = 1'b1;
    send_beat(8'd128, 1'b0, 1'b1);
    err_clr = 1'b0;
    check("clr_wins", 32'(err), 32'd0);
    send_beat(8'd90,  1'b0, 1'b0);
    send_beat(8'd81,  1'b0, 1'b0);
    send_beat(8'd240, 1'b0, 1'b1);
    check("cr_tlast_err", 32'(err), 32'd1);
    drain("cr_tlast");
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;

    // Enable low flushes the partial pair; SOF resynchronises mid-pair.
    send_beat(8'd1, 1'b1, 1'b0);
    send_beat(8'd2, 1'b0, 1'b0);
    en = 1'b0;
    @(negedge clk);
    check("en_low_tready", 32'(s_tready), 32'd0);
    @(posedge clk);
    #1;
    en = 1'b1;
    exp_q.push_back(pw(24'hFF0000, 1'b0, 1'b0));
    exp_q.push_back(pw(24'hFF0000, 1'b0, 1'b1));
    send_pair(8'd90, 8'd81, 8'd240, 8'd81, 1'b0, 1'b1);
    send_beat(8'd5, 1'b0, 1'b0);
    send_beat(8'd6, 1'b0, 1'b0);
    exp_q.push_back(pw(24'h000000, 1'b1, 1'b0));
    exp_q.push_back(pw(24'hFFFFFF, 1'b0, 1'b1));
    send_pair(8'd128, 8'd16, 8'd128, 8'd235, 1'b1, 1'b1);
    drain("enable_sof");
    check("err_quiet", 32'(err), 32'd0);

    // 1280-beat line under random backpressure.
    for (int p = 0; p < 320; p++) begin
      exp_q.push_back(pw(ref_rgb(int'(line_val(p, 1)), int'(line_val(p, 0)), int'(line_val(p, 2))),
                         p == 0, 1'b0));
      exp_q.push_back(pw(ref_rgb(int'(line_val(p, 3)), int'(line_val(p, 0)), int'(line_val(p, 2))),
                         1'b0, p == 319));
    end
    bp_en = 1'b1;
    for (int p = 0; p < 320; p++) begin
      send_beat(line_val(p, 0), p == 0, 1'b0);
      send_beat(line_val(p, 1), 1'b0, 1'b0);
      send_beat(line_val(p, 2), 1'b0, 1'b0);
      send_beat(line_val(p, 3), 1'b0, p == 319);
    end
    drain("line");
    bp_en = 1'b0;
    @(posedge clk);
    #2;
    snk.tready = 1'b1;

    // Asynchronous reset with pixels in flight.
    mon_en = 1'b0;
    snk.tready = 1'b0;
    send_pair(8'd90, 8'd81, 8'd240, 8'd81, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_tvalid", 32'(snk.tvalid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_tvalid", 32'(snk.tvalid), 32'd0);
    check("arst_tdata",  32'(snk.tdata),  32'd0);
    check("arst_tuser",  32'(snk.tuser),  32'd0);
    check("arst_tlast",  32'(snk.tlast),  32'd0);
    check("arst_s_tready", 32'(s_tready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    snk.tready = 1'b1;
    exp_q.delete();
    mon_en = 1'b1;
    exp_q.push_back(pw(24'hFF0000, 1'b1, 1'b0));
    exp_q.push_back(pw(24'hFF0000, 1'b0, 1'b1));
    send_pair(8'd90, 8'd81, 8'd240, 8'd81, 1'b1, 1'b1);
    drain("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
